// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, FSM states,
// response codes, and the request fault check.
package lsu_pkg;

  localparam int MEM_BYTES = 1024;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_FUNCT3   = 2'b11;

  // Highest-priority fault wins: illegal funct3, then alignment, then range.
  function automatic logic [1:0] check_req(input logic write, input logic [2:0] funct3,
                                           input logic [31:0] addr);
    logic        legal;
    logic        misaligned;
    logic [32:0] last_byte;
    legal = write ? (funct3 == F3_B || funct3 == F3_H || funct3 == F3_W)
                  : (funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                     funct3 == F3_BU || funct3 == F3_HU);
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    // The memory always reads a full word, so the last touched byte is addr+3.
    last_byte = {1'b0, addr} + 33'd3;
    if (!legal)
      return ERR_FUNCT3;
    else if (misaligned)
      return ERR_MISALIGN;
    else if (last_byte > 33'(MEM_BYTES - 1))
      return ERR_RANGE;
    else
      return ERR_OK;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data path: load byte/halfword extraction with extension,
// and store merging of the new low bytes into the word read from memory.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [2:0] store_bytes;

  always_comb begin
    load_data = mem_word;
    case (funct3)
      F3_B:    load_data = {{24{mem_word[7]}}, mem_word[7:0]};
      F3_H:    load_data = {{16{mem_word[15]}}, mem_word[15:0]};
      F3_BU:   load_data = {24'b0, mem_word[7:0]};
      F3_HU:   load_data = {16'b0, mem_word[15:0]};
      default: load_data = mem_word;
    endcase
  end

  assign store_bytes = (funct3[1:0] == 2'b00) ? 3'd1 :
                       (funct3[1:0] == 2'b01) ? 3'd2 : 3'd4;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merge_data[gi*8 +: 8] = (3'(gi) < store_bytes) ? store_data[gi*8 +: 8]
                                                          : mem_word[gi*8 +: 8];
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding request, byte/half/word access to a
// 1 KiB word-read memory, with read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      state_reg, state_next;
  logic        write_reg, write_next;
  logic [2:0]  funct3_reg, funct3_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] data_reg, data_next;
  logic [31:0] rdata_reg, rdata_next;
  logic [1:0]  err_reg, err_next;
  logic [1:0]  req_err;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign req_err = check_req(req_write, req_funct3, req_addr);

  lsu_align u_align (
    .funct3     (funct3_reg),
    .mem_word   (mem_rdata),
    .store_data (data_reg),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      write_reg  <= 1'b0;
      funct3_reg <= 3'b0;
      addr_reg   <= 32'b0;
      data_reg   <= 32'b0;
      rdata_reg  <= 32'b0;
      err_reg    <= ERR_OK;
    end else begin
      state_reg  <= state_next;
      write_reg  <= write_next;
      funct3_reg <= funct3_next;
      addr_reg   <= addr_next;
      data_reg   <= data_next;
      rdata_reg  <= rdata_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    write_next  = write_reg;
    funct3_next = funct3_reg;
    addr_next   = addr_reg;
    data_next   = data_reg;
    rdata_next  = rdata_reg;
    err_next    = err_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          write_next  = req_write;
          funct3_next = req_funct3;
          addr_next   = req_addr;
          data_next   = req_wdata;
          rdata_next  = 32'b0;
          err_next    = req_err;
          // Only a full-word store can skip the read of the old word.
          if (req_err != ERR_OK)
            state_next = RESP;
          else if (req_write && req_funct3 == F3_W)
            state_next = WRITE;
          else
            state_next = READ;
        end
      end
      READ: begin
        if (write_reg) begin
          data_next  = merge_data;
          state_next = WRITE;
        end else begin
          rdata_next = load_data;
          state_next = RESP;
        end
      end
      WRITE:   state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_reg == IDLE);
    resp_valid = (state_reg == RESP);
    resp_rdata = (state_reg == RESP) ? rdata_reg : 32'b0;
    resp_err   = (state_reg == RESP) ? err_reg : ERR_OK;
    mem_read   = (state_reg == READ);
    mem_write  = (state_reg == WRITE);
    mem_addr   = (state_reg == READ || state_reg == WRITE) ? addr_reg : 32'b0;
    mem_wdata  = (state_reg == WRITE) ? data_reg : 32'b0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios, then random
// traffic checked against a byte-array reference model.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] mem [0:1023];
  logic [7:0] ref_mem [0:1023];
  logic       preload;
  int         rd_cnt = 0;
  int         wr_cnt = 0;
  int         addr_bad = 0;
  logic [31:0] cur_addr;

  load_store_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = 32'b0;
    for (int i = 0; i < 4; i++)
      if ({32'b0, a} + 64'(i) < 64'd1024) w[i*8 +: 8] = mem[a + 32'(i)];
    return w;
  endfunction

  always_comb mem_rdata = mem_word(mem_addr);

  // Memory model: preload from the reference image, then 4-byte writes.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= ref_mem[i];
    end else if (mem_write && mem_addr <= 32'd1020) begin
      for (int i = 0; i < 4; i++) mem[mem_addr + 32'(i)] <= mem_wdata[i*8 +: 8];
    end
  end

  always @(posedge clk) begin
    if (mem_read) rd_cnt <= rd_cnt + 1;
    if (mem_write) wr_cnt <= wr_cnt + 1;
    if ((mem_read || mem_write) && mem_addr != cur_addr) addr_bad <= addr_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference rules, written directly from the access semantics.
  function automatic logic [1:0] ref_err(input logic wr, input logic [2:0] f3,
                                         input logic [31:0] addr);
    bit legal;
    int size;
    legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    if (!legal) return 2'd3;
    if (addr % size != 0) return 2'd1;
    if (longint'({32'b0, addr}) + 3 > 1023) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    int b0, h0, w0;
    b0 = int'(ref_mem[addr]);
    h0 = b0 + 256 * int'(ref_mem[addr + 1]);
    w0 = h0 + 65536 * int'(ref_mem[addr + 2]) + 16777216 * int'(ref_mem[addr + 3]);
    case (f3)
      3'd0:    return (b0 >= 128) ? 32'(b0 - 256) : 32'(b0);
      3'd1:    return (h0 >= 32768) ? 32'(h0 - 65536) : 32'(h0);
      3'd4:    return 32'(b0);
      3'd5:    return 32'(h0);
      default: return 32'(w0);
    endcase
  endfunction

  task automatic do_op(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int hold);
    logic [1:0]  e_err;
    logic [31:0] e_rd;
    int e_lat, e_rds, e_wrs, size, lat, rd0, wr0, bad0;
    e_err = ref_err(wr, f3, addr);
    e_rd  = 32'b0;
    e_rds = 0;
    e_wrs = 0;
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    if (e_err != 2'd0) begin
      e_lat = 1;
    end else if (!wr) begin
      e_lat = 2; e_rds = 1;
      e_rd  = ref_load(f3, addr);
    end else begin
      e_lat = (size == 4) ? 2 : 3;
      e_rds = (size == 4) ? 0 : 1;
      e_wrs = 1;
      for (int i = 0; i < size; i++) ref_mem[addr + 32'(i)] = wd[i*8 +: 8];
    end

    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    cur_addr   = addr;
    rd0 = rd_cnt; wr0 = wr_cnt; bad0 = addr_bad;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 8);
    check("latency", 32'(lat), 32'(e_lat));
    check("rdata", resp_rdata, e_rd);
    check("err", 32'(resp_err), 32'(e_err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, e_rd);
      check("hold_err", 32'(resp_err), 32'(e_err));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check("resp_cleared", 32'(resp_valid), 32'd0);
    check("mem_reads", 32'(rd_cnt - rd0), 32'(e_rds));
    check("mem_writes", 32'(wr_cnt - wr0), 32'(e_wrs));
    check("mem_addr", 32'(addr_bad - bad0), 32'd0);
    $display("[TB] op wr=%0d f3=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
             wr, f3, addr, wd, resp_rdata, resp_err, lat);
  endtask

  initial begin
    logic [31:0] addr, word_before;
    logic [2:0]  f3;
    logic        wr;
    int          size;

    reset = 1'b0; preload = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'b0; req_wdata = 32'b0; resp_ready = 1'b0; cur_addr = 32'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
    ref_mem[0] = 8'h02; ref_mem[1] = 8'h04; ref_mem[2] = 8'h08; ref_mem[3] = 8'h10;
    ref_mem[16] = 8'h0D; ref_mem[17] = 8'h01;

    #2;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    reset = 1'b1;

    do_op(1'b0, 3'd2, 32'd0, 32'd0, 0);
    do_op(1'b0, 3'd1, 32'd16, 32'd0, 0);
    do_op(1'b0, 3'd1, 32'd2, 32'd0, 0);
    do_op(1'b1, 3'd0, 32'd0, 32'h0000_00FF, 0);
    do_op(1'b0, 3'd0, 32'd0, 32'd0, 0);
    do_op(1'b0, 3'd4, 32'd0, 32'd0, 0);
    do_op(1'b1, 3'd0, 32'd0, 32'h0000_0002, 0);
    do_op(1'b1, 3'd0, 32'd1, 32'h0000_00AB, 0);
    do_op(1'b0, 3'd2, 32'd0, 32'd0, 0);
    check("lw_after_sb_const", mem_word(32'd0), 32'h1008_AB02);
    do_op(1'b0, 3'd1, 32'd1, 32'd0, 0);
    do_op(1'b1, 3'd2, 32'd1021, 32'h1234_5678, 0);
    do_op(1'b0, 3'd3, 32'd4, 32'd0, 0);
    do_op(1'b0, 3'd2, 32'hFFFF_FFFC, 32'd0, 0);
    do_op(1'b1, 3'd2, 32'd1020, 32'hCAFE_F00D, 0);
    do_op(1'b0, 3'd2, 32'd1020, 32'd0, 0);
    do_op(1'b0, 3'd2, 32'd0, 32'd0, 5);

    // Abort a word store mid-flight with reset.
    word_before = mem_word(32'd8);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'd8; req_wdata = 32'hDEAD_BEEF; cur_addr = 32'd8;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort_in_write", 32'(mem_write), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("abort_mem_write", 32'(mem_write), 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    check("abort_mem_wdata", mem_wdata, 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check("abort_word_kept", mem_word(32'd8), word_before);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_resp", 32'(resp_valid), 32'd0);
    end

    for (int n = 0; n < 150; n++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 5));
      size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      addr = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(size - 1);
      if ($urandom_range(0, 15) == 0) addr = $urandom;
      do_op(wr, f3, addr, $urandom, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
